chunked_subtractor: RTL and testbench

- Multi-cycle WIDTH-bit unsigned subtractor with borrow-in/borrow-out: diff = a - b - bin.
- Processes CHUNK bits per cycle, LSB chunk first, and ripples the borrow between chunks through a register.
- Operands and results use valid/ready handshakes, so the block sits between a stimulus/producer stage and a result consumer.
- Companion to the team's wide combinational ripple adder: the inverse operation, built sequentially.

---
 rtl/chunked_subtractor.sv | 143 ++++++++++++++
 tb/tb_chunked_subtractor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/chunked_subtractor.sv
// rtl/chunked_subtractor.sv - multi-cycle chunked WIDTH-bit subtractor with valid/ready handshakes
//
// Computes diff = (a - b - bin) mod 2^WIDTH and bout = (a < b + bin), CHUNK bits per
// cycle, LSB chunk first. The borrow between chunks is held in a register.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready   operand handshake (in_ready only in IDLE)
//   a, b, bin            minuend, subtrahend, borrow-in
//   out_valid, out_ready result handshake (out_valid only in DONE)
//   diff, bout           result and borrow-out, held stable while out_valid
//   ovf                  signed overflow, present only with CHUNKED_SUBTRACTOR_OVF_EN
//
// Optional feature macro: CHUNKED_SUBTRACTOR_OVF_EN
module chunked_subtractor #(
    parameter int WIDTH = 100,
    parameter int CHUNK = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [IDXW-1:0]  idx_q,    idx_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             bout_q,   bout_d;
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
    logic             ovf_q,    ovf_d;
`endif

    // One extra bit on top of the chunk: after the subtraction it is set exactly
    // when the chunk result went negative, i.e. it is the outgoing borrow.
    logic [CHUNK:0]   sub;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
        ovf_d    = ovf_q;
`endif
        sub = {1'b0, a_q[idx_q*CHUNK +: CHUNK]}
            - {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
            - {{CHUNK{1'b0}}, borrow_q};

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    idx_d    = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                diff_d[idx_q*CHUNK +: CHUNK] = sub[CHUNK-1:0];
                borrow_d = sub[CHUNK];
                if (idx_q == LAST_IDX) begin
                    bout_d  = sub[CHUNK];
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
                    // The last chunk holds the result MSB, so overflow is known now.
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (sub[CHUNK-1] != a_q[WIDTH-1]);
`endif
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_subtractor.sv
// tb/tb_chunked_subtractor.sv - randomized self-checking bench for chunked_subtractor
module tb_chunked_subtractor;

    localparam int W   = 100;
    localparam int NCH = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         bout;
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    chunked_subtractor #(.WIDTH(W), .CHUNK(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    // Reference: unsigned difference with one guard bit; guard bit is the borrow-out.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    endfunction

    // Reference: exact signed difference in a wider field, overflow if it leaves W-bit range.
    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic c);
        logic [W+1:0] s;
        s = {{2{x[W-1]}}, x} - {{2{y[W-1]}}, y} - {{(W+1){1'b0}}, c};
        return !((s[W+1:W-1] == 3'b000) || (s[W+1:W-1] == 3'b111));
    endfunction

    task automatic wait_in_ready(input string tag);
        int cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!in_ready) check({tag, "_in_ready_timeout"}, 0, 1);
    endtask

    task automatic wait_out_valid(input string tag, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!out_valid) check({tag, "_out_valid_timeout"}, 0, 1);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] x,
                                input logic [W-1:0] y, input logic c);
        logic [W:0] r;
        r = ref_sub(x, y, c);
        check({tag, "_diff"}, diff, r[W-1:0]);
        check({tag, "_bout"}, bout, r[W]);
`ifdef CHUNKED_SUBTRACTOR_OVF_EN
        check({tag, "_ovf"}, ovf, ref_ovf(x, y, c));
`endif
    endtask

    // Full operation with out_ready high: latency, result, return to IDLE.
    task automatic run_op(input string tag, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic c);
        int cyc;
        wait_in_ready(tag);
        a = x; b = y; bin = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // scramble inputs: the block must use its own copies
        a = rnd_w(); b = rnd_w(); bin = 1'($urandom);
        check({tag, "_busy"}, in_ready, 0);
        wait_out_valid(tag, cyc);
        check({tag, "_latency"}, cyc, NCH);
        check({tag, "_in_ready_done"}, in_ready, 0);
        check_result(tag, x, y, c);
        @(posedge clk); #1;
        check({tag, "_out_valid_fall"}, out_valid, 0);
        check({tag, "_in_ready_back"}, in_ready, 1);
    endtask

    logic [W-1:0] ones;
    logic [W-1:0] msb;
    logic [W-1:0] held_diff;
    logic         held_bout;
    logic [W-1:0] na, nb;
    int           cyc;

    initial begin
        ones = '1;
        msb  = '0;
        msb[W-1] = 1'b1;

        // reset state
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // directed cases
        run_op("d_5m3", W'(5), W'(3), 1'b0);
        run_op("d_0m1", '0, W'(1), 1'b0);
        run_op("d_ones_bin", ones, ones, 1'b1);
        run_op("d_ones_m0", ones, '0, 1'b0);
        run_op("d_msb_m1", msb, W'(1), 1'b0);
        run_op("d_msbm1_mones", msb - 1'b1, ones, 1'b0);
        run_op("d_0m0_bin", '0, '0, 1'b1);

        // random cases
        for (int i = 0; i < 20; i++) begin
            run_op($sformatf("rnd%0d", i), rnd_w(), rnd_w(), 1'($urandom));
        end

        // backpressure: result held, new operands refused while DONE
        out_ready = 1'b0;
        wait_in_ready("bp");
        na = rnd_w(); nb = rnd_w();
        a = na; b = nb; bin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out_valid("bp", cyc);
        check_result("bp_first", na, nb, 1'b1);
        held_diff = diff;
        held_bout = bout;
        na = rnd_w(); nb = rnd_w();
        a = na; b = nb; bin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid_held", out_valid, 1);
            check("bp_diff_held", diff, held_diff);
            check("bp_bout_held", bout, held_bout);
            check("bp_in_ready_low", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_new_accepted", in_ready, 0);
        wait_out_valid("bp_new", cyc);
        check("bp_new_latency", cyc, NCH);
        check_result("bp_new", na, nb, 1'b0);
        @(posedge clk); #1;

        // asynchronous reset mid-CALC at idx 4
        wait_in_ready("rst");
        a = rnd_w(); b = rnd_w(); bin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_diff", diff, 0);
        check("arst_bout", bout, 0);
        check("arst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", W'(100), W'(58), 1'b0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
